// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies the synchronized lock
// flag and holds sys_rst until lock has been stable; retries on lock timeout.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 8,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             locked,
    input  logic             force_relock,
    output logic             pll_areset,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_AB = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] STB_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       retry_q, retry_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= PLL_RST;
            timer_q <= '0;
            sync_q  <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sync_q  <= sync_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], locked};
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            PLL_RST: begin
                // force_relock is deliberately ignored here so the pulse is never stretched
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                end else if (locked_s) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == TOUT_LAST) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STABLE: begin
                if (force_relock) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STB_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                if (force_relock) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            default: begin
                state_d = PLL_RST;
                timer_d = '0;
            end
        endcase
    end

    assign pll_areset    = (state_q == PLL_RST);
    assign sys_rst       = (state_q != RUN);
    assign ready         = (state_q == RUN);
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus pushes expected state/counter changes with their
// edge index; a negedge monitor pops one entry on every observed change.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       areset;
    logic       locked;
    logic       force_relock;
    logic       pll_areset, sys_rst, ready;
    logic [1:0] state;
    logic [7:0] retry_cnt, lock_loss_cnt;

    pll_lock_sequencer dut (
        .clk(clk), .areset(areset), .locked(locked), .force_relock(force_relock),
        .pll_areset(pll_areset), .sys_rst(sys_rst), .ready(ready), .state(state),
        .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    always #10 clk = ~clk;

    typedef struct {
        int cyc;
        int st;
        int rc;
        int lc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m_rc = 0;
    int   m_lc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(int c, int st);
        exp_t e;
        e.cyc = c; e.st = st; e.rc = m_rc; e.lc = m_lc;
        q.push_back(e);
    endfunction

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: any change of state or counters must match the next queued entry
    logic [17:0] prev = '0;
    always @(negedge clk) begin
        logic [17:0] cur;
        exp_t        e;
        if (areset) begin
            prev = '0;
        end else begin
            cur = {state, retry_cnt, lock_loss_cnt};
            if (cur != prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_change_state", int'(state), -1);
                end else begin
                    e = q.pop_front();
                    chk("edge_index", cyc, e.cyc);
                    chk("state", int'(state), e.st);
                    chk("retry_cnt", int'(retry_cnt), e.rc);
                    chk("lock_loss_cnt", int'(lock_loss_cnt), e.lc);
                    chk("pll_areset", int'(pll_areset), int'(e.st == 0));
                    chk("sys_rst", int'(sys_rst), int'(e.st != 3));
                    chk("ready", int'(ready), int'(e.st == 3));
                end
            end
            prev = cur;
        end
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_pll_areset"}, int'(pll_areset), 1);
        chk({tag, "_sys_rst"}, int'(sys_rst), 1);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
        chk({tag, "_loss"}, int'(lock_loss_cnt), 0);
    endtask

    initial begin
        int r, k, f, g, d;
        areset = 1'b1; locked = 1'b0; force_relock = 1'b0;
        #50;
        chk_reset_outputs("reset");
        #50;

        // Release with no lock: 8-cycle PLL pulse, timeout after 1000, retry
        @(negedge clk);
        areset = 1'b0;
        r = cyc;
        push(r + 8, 1);
        m_rc = 1;
        push(r + 1008, 0);
        push(r + 1016, 1);

        // Clean lock: ready 19 edges after the rise
        wait_cyc(r + 1030);
        k = cyc; locked = 1'b1;
        push(k + 3, 2);
        push(k + 19, 3);

        // force_relock in RUN, again during PLL_RST (ignored); lock dropped meanwhile
        wait_cyc(k + 30);
        f = cyc; force_relock = 1'b1; locked = 1'b0;
        push(f + 1, 0);
        push(f + 9, 1);
        @(negedge clk); force_relock = 1'b0;
        wait_cyc(f + 3); force_relock = 1'b1;
        @(negedge clk); force_relock = 1'b0;

        // Lock, then 3-cycle drop at STABLE count 10: no lock_loss increment
        wait_cyc(f + 20);
        g = cyc; locked = 1'b1;
        push(g + 3, 2);
        wait_cyc(g + 13);
        d = cyc; locked = 1'b0;
        push(d + 3, 1);
        wait_cyc(d + 3); locked = 1'b1;
        push(d + 6, 2);
        push(d + 22, 3);

        // 300 lock drops in RUN: lock_loss_cnt saturates at 255
        wait_cyc(d + 30);
        for (int i = 0; i < 300; i++) begin
            k = cyc; locked = 1'b0;
            if (m_lc < 255) m_lc++;
            push(k + 3, 1);
            wait_cyc(k + 2); locked = 1'b1;
            push(k + 5, 2);
            push(k + 21, 3);
            wait_cyc(k + 25);
        end

        // Async reset in the middle of STABLE, between edges
        k = cyc; locked = 1'b0;
        push(k + 3, 1);
        wait_cyc(k + 2); locked = 1'b1;
        push(k + 5, 2);
        wait_cyc(k + 10);
        #3; areset = 1'b1;
        #1;
        chk_reset_outputs("async");
        chk("pending_before_async", q.size(), 0);
        m_rc = 0; m_lc = 0;
        @(negedge clk); @(negedge clk);
        areset = 1'b0;
        r = cyc;
        push(r + 8, 1);
        push(r + 9, 2);
        push(r + 25, 3);

        wait_cyc(r + 40);
        chk("pending_at_end", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
